// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 timing constants shared by sync and pixel stages.
// Revision : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int c_cnt_w      = 10;

    localparam int c_h_display  = 640;
    localparam int c_h_front    = 16;
    localparam int c_h_back     = 48;
    localparam int c_h_retrace  = 96;
    localparam int c_h_total    = c_h_display + c_h_front + c_h_back + c_h_retrace;

    localparam int c_v_display  = 480;
    localparam int c_v_front    = 10;
    localparam int c_v_back     = 33;
    localparam int c_v_retrace  = 2;
    localparam int c_v_total    = c_v_display + c_v_front + c_v_back + c_v_retrace;

    // Inclusive window test used for both sync pulses.
    function automatic logic in_window(input logic [c_cnt_w-1:0] v,
                                       input logic [c_cnt_w-1:0] lo,
                                       input logic [c_cnt_w-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : vga_tick_div
// Brief    : Divides clk by CLK_DIV (>= 2) into a one-clk pixel strobe.
// Revision : 1.0
// ============================================================================
module vga_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int                 c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0] r_div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_div_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign p_tick = (r_div_cnt == c_div_last);

endmodule
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync
// Brief    : VGA raster counters and sync generation; frame counter present
//            only when VGA_SYNC_FRAME_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = c_h_display,
    parameter int H_FRONT   = c_h_front,
    parameter int H_BACK    = c_h_back,
    parameter int H_RETRACE = c_h_retrace,
    parameter int V_DISPLAY = c_v_display,
    parameter int V_FRONT   = c_v_front,
    parameter int V_BACK    = c_v_back,
    parameter int V_RETRACE = c_v_retrace
) (
    input  logic        clk,
    input  logic        reset,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        p_tick,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);

    localparam int         c_h_tot    = H_DISPLAY + H_FRONT + H_BACK + H_RETRACE;
    localparam int         c_v_tot    = V_DISPLAY + V_FRONT + V_BACK + V_RETRACE;
    localparam logic [9:0] c_h_last   = 10'(c_h_tot - 1);
    localparam logic [9:0] c_v_last   = 10'(c_v_tot - 1);
    localparam logic [9:0] c_h_disp   = 10'(H_DISPLAY);
    localparam logic [9:0] c_v_disp   = 10'(V_DISPLAY);
    localparam logic [9:0] c_hs_start = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_hs_end   = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [9:0] c_vs_start = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_vs_end   = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

    logic       w_p_tick;
    logic       w_h_end;
    logic       w_v_end;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_hsync;
    logic       r_vsync;

    vga_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk     (clk),
        .reset   (reset),
        .p_tick  (w_p_tick)
    );

    assign w_h_end = (r_h_cnt == c_h_last);
    assign w_v_end = (r_v_cnt == c_v_last);

    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (w_p_tick) begin
            w_h_next = w_h_end ? 10'd0 : r_h_cnt + 10'd1;
            if (w_h_end) begin
                w_v_next = w_v_end ? 10'd0 : r_v_cnt + 10'd1;
            end
        end
    end

    // Syncs decode the next count so they line up with pix_x/pix_y, not a pixel late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
            r_hsync <= ~in_window(w_h_next, c_hs_start, c_hs_end);
            r_vsync <= ~in_window(w_v_next, c_vs_start, c_vs_end);
        end
    end

    assign p_tick     = w_p_tick;
    assign pix_x      = r_h_cnt;
    assign pix_y      = r_v_cnt;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = (r_h_cnt < c_h_disp) && (r_v_cnt < c_v_disp);
    assign frame_tick = w_p_tick && w_h_end && w_v_end;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= 16'h0000;
        end else if (frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, system clocks per pixel tick (at least 2).
REQ-002 SHALL have parameters H_DISPLAY 640, H_FRONT 16, H_BACK 48, H_RETRACE 96, giving the horizontal timing in pixels.
REQ-003 SHALL have parameters V_DISPLAY 480, V_FRONT 10, V_BACK 33, V_RETRACE 2, giving the vertical timing in lines.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-007 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-008 SHALL have port video_on, output, 1, high while (pix_x, pix_y) is inside the display area.
REQ-009 SHALL have port p_tick, output, 1, one-clk pulse per pixel period.
REQ-010 SHALL have port pix_x, output, 10, current horizontal count.
REQ-011 SHALL have port pix_y, output, 10, current vertical count.
REQ-012 SHALL have port frame_tick, output, 1, one-clk pulse on the last pixel of each frame.
REQ-013 SHALL have port frame_cnt, output, 16, completed-frame count.

Function
REQ-014 SHALL define H_TOTAL = H_DISPLAY+H_FRONT+H_BACK+H_RETRACE (800) and V_TOTAL = V_DISPLAY+V_FRONT+V_BACK+V_RETRACE (525).
REQ-015 SHALL use a divider counter div_cnt that counts 0..CLK_DIV-1 and wraps; p_tick SHALL be 1 exactly when div_cnt == CLK_DIV-1.
REQ-016 SHALL advance h_cnt only on a clk edge where p_tick=1; from H_TOTAL-1 it SHALL wrap to 0.
REQ-017 SHALL advance v_cnt only where p_tick=1 and h_cnt == H_TOTAL-1; from V_TOTAL-1 it SHALL wrap to 0.
REQ-018 SHALL drive pix_x = h_cnt and pix_y = v_cnt directly from registers.
REQ-019 SHALL drive video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY), combinationally from the counter registers.
REQ-020 SHALL register hsync from the next-state h_cnt, so hsync=0 exactly while pix_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_RETRACE-1] = [656,751].
REQ-021 SHALL register vsync from the next-state v_cnt, so vsync=0 exactly while pix_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_RETRACE-1] = [490,491].
REQ-022 SHALL assert frame_tick for exactly the clk where p_tick=1, h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1.
REQ-023 SHALL increment frame_cnt on each frame_tick, wrapping from 0xFFFF to 0x0000.
REQ-024 SHALL keep every output at a fixed pixel rate, with no gaps and no added latency beyond REQ-015..REQ-021.

Reset
REQ-025 SHALL, while reset=0, force div_cnt=0, h_cnt=0, v_cnt=0, frame_cnt=0, hsync=1, vsync=1, p_tick=0, frame_tick=0 and video_on=1, asynchronously.
REQ-026 SHALL, when reset is asserted mid-frame, abandon the frame and restart from pixel (0,0); the first p_tick SHALL occur on the CLK_DIV-th clk edge after reset is released.

Configuration
REQ-027 SHALL, when macro VGA_SYNC_FRAME_CNT_EN is defined, implement frame_cnt as in REQ-023.
REQ-028 SHALL, when VGA_SYNC_FRAME_CNT_EN is not defined, omit the frame counter register and tie frame_cnt to 16'h0000; frame_tick SHALL still operate.

Structure
REQ-029 SHALL place the default timing constants and the derived H_TOTAL and V_TOTAL in shared package vga_timing_pkg, for reuse by the pixel-generation stage.
REQ-030 SHALL implement the divider in one sub-module, vga_tick_div (parameter CLK_DIV, output p_tick); the counters and sync logic SHALL stay in vga_sync.

Verification
REQ-031 SHALL verify reset: hold reset=0 for 3 clk, release -> p_tick first high on clk 4; pix_x=0, pix_y=0, hsync=1, vsync=1, video_on=1.
REQ-032 SHALL verify the line: run 800 p_ticks -> pix_x goes 0..799 then 0; video_on falls at pix_x=640; hsync=0 for exactly pix_x 656..751 (96 ticks); pix_y increments once.
REQ-033 SHALL verify the frame: run 420000 p_ticks -> vsync=0 only for pix_y 490..491 (1600 ticks); a single frame_tick at (799,524); frame_cnt=1 (macro on) or 0 (macro off).
REQ-034 SHALL verify mid-frame reset: assert reset at pix_x=300, pix_y=200 -> all outputs return to REQ-025 values within the same clk; the restart timing matches REQ-031.
REQ-035 SHALL verify wrap: preload frame_cnt to 0xFFFF, run one frame -> frame_cnt=0x0000 on the clk after frame_tick.
REQ-036 SHALL verify CLK_DIV=2: p_tick toggles on every 2nd clk; one line spans exactly 1600 clk.
